// File: rtl/axis_i2s2_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : axis_i2s2_transceiver
// Description : Pmod I2S2 serial front end. Generates SCLK/LRCK from MCLK,
//               deserialises stereo ADC frames into 2-word AXIS packets
//               (left, then right with last=1) and serialises 2-word AXIS
//               packets back out to the DAC one frame after they complete.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_i2s2_transceiver #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  resetn,
    // DAC-bound sample stream
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    // ADC-sourced sample stream
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    // Pmod I2S2 pins
    output logic                  tx_lrck,
    output logic                  tx_sclk,
    output logic                  tx_sdout,
    output logic                  rx_lrck,
    output logic                  rx_sclk,
    input  logic                  rx_sdin,
    output logic                  rx_overrun
);

    // Last slot that carries a sample bit; later slots of a half-frame are zero.
    localparam logic [4:0] c_LAST_SLOT = 5'(DATA_WIDTH);
    // Zero padding that left-aligns a sample inside a 32-bit slot window.
    localparam int         c_PAD       = 32 - DATA_WIDTH;
    localparam logic [8:0] c_CNT_LAST  = 9'd511;
    localparam logic [2:0] c_RX_PHASE  = 3'd3;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [8:0]            r_cnt;
    logic                  r_sdout;
    logic                  r_tx_full;
    logic [DATA_WIDTH-1:0] r_tx_hold_left;
    logic [DATA_WIDTH-1:0] r_tx_hold_right;
    logic [DATA_WIDTH-1:0] r_tx_word_left;
    logic [DATA_WIDTH-1:0] r_tx_word_right;
    logic [DATA_WIDTH-1:0] r_rx_shift_left;
    logic [DATA_WIDTH-1:0] r_rx_shift_right;
    logic [DATA_WIDTH-1:0] r_rx_hold_right;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic                  r_overrun;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [8:0]            w_cnt_next;
    logic [4:0]            w_slot;
    logic                  w_tx_frame_start;
    logic                  w_rx_frame_end;
    logic                  w_rx_sample;
    logic                  w_s_fire;
    logic                  w_m_fire;
    logic [DATA_WIDTH-1:0] w_tx_word_next;
    logic [31:0]           w_tx_window;
    logic [4:0]            w_tx_bit_idx;
    logic                  w_tx_bit_next;

    assign w_cnt_next       = r_cnt + 9'd1;
    assign w_slot           = r_cnt[7:3];
    assign w_tx_frame_start = (r_cnt == 9'd0);
    assign w_rx_frame_end   = (r_cnt == c_CNT_LAST);

    // ADC data is taken one MCLK before SCLK rises, inside the sample slots only.
    assign w_rx_sample      = (r_cnt[2:0] == c_RX_PHASE) &&
                              (w_slot != 5'd0) && (w_slot <= c_LAST_SLOT);

    assign w_s_fire         = s_axis_valid & ~r_tx_full;
    assign w_m_fire         = r_m_valid & m_axis_ready;

    // The serial bit is chosen for the slot the counter is about to enter.
    // With the word left-aligned in a 32-bit window, slot s maps to bit
    // 32-s = ~(s-1); slot 0 lands on bit 0 and trailing slots land on the
    // zero padding, so the delay bit and the tail come out as 0 for free.
    assign w_tx_word_next   = w_cnt_next[8] ? r_tx_word_right : r_tx_word_left;
    assign w_tx_window      = {w_tx_word_next, {c_PAD{1'b0}}};
    assign w_tx_bit_idx     = ~(w_cnt_next[7:3] - 5'd1);
    assign w_tx_bit_next    = w_tx_window[w_tx_bit_idx];

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx_sclk      = r_cnt[2];
    assign rx_sclk      = r_cnt[2];
    assign tx_lrck      = r_cnt[8];
    assign rx_lrck      = r_cnt[8];
    assign tx_sdout     = r_sdout;
    assign s_axis_ready = ~r_tx_full;
    assign m_axis_data  = r_m_data;
    assign m_axis_valid = r_m_valid;
    assign m_axis_last  = r_m_last;
    assign rx_overrun   = r_overrun;

    // Free-running frame counter: SCLK, LRCK and slot timing all derive from it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= 9'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Collect an incoming DAC packet; a complete packet blocks input until the frame start.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tx_full       <= 1'b0;
            r_tx_hold_left  <= '0;
            r_tx_hold_right <= '0;
        end else if (w_tx_frame_start && r_tx_full) begin
            // Packet moves to the frame registers; leave no stale left word behind.
            r_tx_full       <= 1'b0;
            r_tx_hold_left  <= '0;
            r_tx_hold_right <= '0;
        end else if (w_s_fire) begin
            if (s_axis_last) begin
                r_tx_hold_right <= s_axis_data;
                r_tx_full       <= 1'b1;
            end else begin
                r_tx_hold_left  <= s_axis_data;
            end
        end
    end

    // Latch the words for the frame just starting; silence when no full packet is waiting.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tx_word_left  <= '0;
            r_tx_word_right <= '0;
        end else if (w_tx_frame_start) begin
            if (r_tx_full) begin
                r_tx_word_left  <= r_tx_hold_left;
                r_tx_word_right <= r_tx_hold_right;
            end else begin
                r_tx_word_left  <= '0;
                r_tx_word_right <= '0;
            end
        end
    end

    // Serial DAC data is registered and only updated on SCLK falling edges.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sdout <= 1'b0;
        end else if (w_cnt_next[2:0] == 3'd0) begin
            r_sdout <= w_tx_bit_next;
        end
    end

    // Shift ADC bits MSB first into the channel selected by LRCK.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rx_shift_left  <= '0;
            r_rx_shift_right <= '0;
        end else if (w_rx_sample) begin
            if (r_cnt[8]) begin
                r_rx_shift_right <= DATA_WIDTH'({r_rx_shift_right, rx_sdin});
            end else begin
                r_rx_shift_left  <= DATA_WIDTH'({r_rx_shift_left, rx_sdin});
            end
        end
    end

    // Present each received frame as left/right words; drop whole frames while one is pending.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_m_data        <= '0;
            r_m_valid       <= 1'b0;
            r_m_last        <= 1'b0;
            r_rx_hold_right <= '0;
            r_overrun       <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_rx_frame_end && !r_m_valid) begin
                r_m_data        <= r_rx_shift_left;
                r_rx_hold_right <= r_rx_shift_right;
                r_m_valid       <= 1'b1;
                r_m_last        <= 1'b0;
            end else begin
                // A pending packet is never disturbed by a newer frame.
                if (w_rx_frame_end) begin
                    r_overrun <= 1'b1;
                end
                if (w_m_fire) begin
                    if (!r_m_last) begin
                        r_m_data <= r_rx_hold_right;
                        r_m_last <= 1'b1;
                    end else begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_i2s2_transceiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_i2s2_transceiver
// Description : Self-checking bench for axis_i2s2_transceiver. A frame-level
//               model (queues, slot arithmetic) predicts every output each
//               cycle; directed scenarios add hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_i2s2_transceiver;

    localparam int DW = 24;

    logic          clk;
    logic          resetn;
    logic [DW-1:0] s_axis_data;
    logic          s_axis_valid;
    logic          s_axis_ready;
    logic          s_axis_last;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic          m_axis_last;
    logic          tx_lrck;
    logic          tx_sclk;
    logic          tx_sdout;
    logic          rx_lrck;
    logic          rx_sclk;
    logic          rx_sdin;
    logic          rx_overrun;

    logic          lb;
    logic          rx_rand;

    assign rx_sdin = lb ? tx_sdout : rx_rand;

    axis_i2s2_transceiver #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .tx_lrck      (tx_lrck),
        .tx_sclk      (tx_sclk),
        .tx_sdout     (tx_sdout),
        .rx_lrck      (rx_lrck),
        .rx_sclk      (rx_sclk),
        .rx_sdin      (rx_sdin),
        .rx_overrun   (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Frame-level reference model
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } mword_t;

    bit            model_on = 1'b0;
    int            mc;                 // position inside the 512-clock frame
    logic [DW-1:0] hold_l, hold_r;     // words accepted for the next frame
    bit            pkt_done;           // right word accepted, waiting for frame start
    logic [DW-1:0] cur_l, cur_r;       // words being sent in this frame
    logic [DW-1:0] rxw [2];            // words being received in this frame
    mword_t        outq [$];           // ADC words waiting to be delivered
    bit            ovr;

    task automatic model_step();
        int     slot;
        int     ch;
        bit     pre_done;
        bit     pre_valid;
        mword_t w;
        if (!resetn) begin
            model_on = 1'b1;
            mc       = 0;
            hold_l   = '0;
            hold_r   = '0;
            pkt_done = 1'b0;
            cur_l    = '0;
            cur_r    = '0;
            rxw[0]   = '0;
            rxw[1]   = '0;
            outq.delete();
            ovr      = 1'b0;
        end else if (model_on) begin
            pre_done  = pkt_done;
            pre_valid = (outq.size() != 0);
            ovr       = 1'b0;
            // ADC bit for slot s of a half lands at weight DW-s
            slot = (mc % 256) / 8;
            ch   = mc / 256;
            if ((mc % 8) == 3 && slot >= 1 && slot <= DW) rxw[ch][DW - slot] = rx_sdin;
            // downstream delivery
            if (pre_valid && m_axis_ready) void'(outq.pop_front());
            if (mc == 511) begin
                if (!pre_valid) begin
                    w.d = rxw[0]; w.l = 1'b0; outq.push_back(w);
                    w.d = rxw[1]; w.l = 1'b1; outq.push_back(w);
                end else begin
                    ovr = 1'b1;
                end
            end
            // upstream acceptance
            if (!pre_done && s_axis_valid) begin
                if (s_axis_last) begin
                    hold_r   = s_axis_data;
                    pkt_done = 1'b1;
                end else begin
                    hold_l   = s_axis_data;
                end
            end
            // frame start picks what goes on the wire this frame
            if (mc == 0) begin
                if (pre_done) begin
                    cur_l = hold_l; cur_r = hold_r;
                    hold_l = '0; hold_r = '0;
                    pkt_done = 1'b0;
                end else begin
                    cur_l = '0; cur_r = '0;
                end
            end
            mc = (mc + 1) % 512;
        end
    endtask

    task automatic compare_step();
        int            slot;
        int            ch;
        logic [DW-1:0] w;
        logic          eb;
        bit            ev;
        if (model_on) begin
            slot = (mc % 256) / 8;
            ch   = mc / 256;
            w    = (ch != 0) ? cur_r : cur_l;
            eb   = (slot >= 1 && slot <= DW) ? w[DW - slot] : 1'b0;
            ev   = (outq.size() != 0);
            chk("tx_sclk",      32'(tx_sclk),      32'((mc / 4) % 2));
            chk("rx_sclk",      32'(rx_sclk),      32'((mc / 4) % 2));
            chk("tx_lrck",      32'(tx_lrck),      32'(mc / 256));
            chk("rx_lrck",      32'(rx_lrck),      32'(mc / 256));
            chk("tx_sdout",     32'(tx_sdout),     32'(eb));
            chk("s_axis_ready", 32'(s_axis_ready), 32'(!pkt_done));
            chk("m_axis_valid", 32'(m_axis_valid), 32'(ev));
            chk("rx_overrun",   32'(rx_overrun),   32'(ovr));
            if (ev) begin
                chk("m_axis_last", 32'(m_axis_last), 32'(outq[0].l));
                chk("m_axis_data", 32'(m_axis_data), 32'(outq[0].d));
            end else begin
                chk("m_axis_last", 32'(m_axis_last), 32'(0));
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        compare_step();
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic wait_mc(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mc != target && n < 1100);
        if (mc != target) begin
            checks++;
            errors++;
            $display("FAIL wait_mc timeout actual=%0d required=%0d", mc, target);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        s_axis_last  = last;
        @(negedge clk);
        s_axis_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    initial begin
        logic [DW-1:0] l4, r4;
        int            ovr_seen;

        resetn       = 1'b0;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        s_axis_last  = 1'b0;
        m_axis_ready = 1'b1;
        lb           = 1'b1;
        rx_rand      = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_sclk",   32'(tx_sclk),      32'(0));
        chk("rst_lrck",   32'(tx_lrck),      32'(0));
        chk("rst_sdout",  32'(tx_sdout),     32'(0));
        chk("rst_ready",  32'(s_axis_ready), 32'(1));
        chk("rst_mvalid", 32'(m_axis_valid), 32'(0));
        chk("rst_mlast",  32'(m_axis_last),  32'(0));
        chk("rst_mdata",  32'(m_axis_data),  32'(0));
        chk("rst_ovr",    32'(rx_overrun),   32'(0));
        resetn = 1'b1;

        // clock generation after release
        wait_mc(3);   chk("sclk_c3",   32'(tx_sclk), 32'(0));
        wait_mc(4);   chk("sclk_c4",   32'(tx_sclk), 32'(1));
        wait_mc(8);   chk("sclk_c8",   32'(tx_sclk), 32'(0));
        wait_mc(255); chk("lrck_c255", 32'(tx_lrck), 32'(0));
        wait_mc(256); chk("lrck_c256", 32'(tx_lrck), 32'(1));

        // loopback of one packet: sent in frame 0, on the wire in frame 1
        send_word(24'hABCDEF, 1'b0);
        send_word(24'h123456, 1'b1);
        wait_mc(0);
        chk("lb_f0_valid", 32'(m_axis_valid), 32'(1));
        chk("lb_f0_data",  32'(m_axis_data),  32'(0));
        wait_mc(0);
        chk("lb_left_valid", 32'(m_axis_valid), 32'(1));
        chk("lb_left_data",  32'(m_axis_data),  32'h00ABCDEF);
        chk("lb_left_last",  32'(m_axis_last),  32'(0));
        @(negedge clk);
        chk("lb_right_data", 32'(m_axis_data),  32'h00123456);
        chk("lb_right_last", 32'(m_axis_last),  32'(1));

        // idle frame: nothing on the wire, input always ready
        repeat (511) begin
            chk("idle_sdout", 32'(tx_sdout),     32'(0));
            chk("idle_ready", 32'(s_axis_ready), 32'(1));
            @(negedge clk);
        end

        // back-pressure across two frame ends
        l4 = DW'($urandom);
        r4 = DW'($urandom);
        send_word(l4, 1'b0);
        send_word(r4, 1'b1);
        wait_mc(0);
        wait_mc(0);
        chk("bp_first_data", 32'(m_axis_data), 32'(l4));
        m_axis_ready = 1'b0;
        ovr_seen = 0;
        repeat (1034) begin
            @(negedge clk);
            if (rx_overrun) ovr_seen++;
            chk("bp_hold_data",  32'(m_axis_data),  32'(l4));
            chk("bp_hold_valid", 32'(m_axis_valid), 32'(1));
        end
        chk("bp_overruns", 32'(ovr_seen), 32'(2));
        m_axis_ready = 1'b1;
        @(negedge clk);
        chk("bp_right_data", 32'(m_axis_data),  32'(r4));
        chk("bp_right_last", 32'(m_axis_last),  32'(1));
        @(negedge clk);
        chk("bp_done_valid", 32'(m_axis_valid), 32'(0));

        // reset for one clock mid-frame with a packet pending on both sides
        m_axis_ready = 1'b0;
        wait_mc(0);
        wait_mc(98);
        send_word(DW'($urandom), 1'b0);
        send_word(DW'($urandom), 1'b1);
        chk("mr_pre_ready", 32'(s_axis_ready), 32'(0));
        chk("mr_pre_valid", 32'(m_axis_valid), 32'(1));
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("mr_valid", 32'(m_axis_valid), 32'(0));
        chk("mr_ready", 32'(s_axis_ready), 32'(1));
        chk("mr_sclk",  32'(tx_sclk),      32'(0));
        chk("mr_lrck",  32'(tx_lrck),      32'(0));
        chk("mr_sdout", 32'(tx_sdout),     32'(0));
        wait_mc(4);
        chk("mr_sclk_c4", 32'(tx_sclk), 32'(1));
        m_axis_ready = 1'b1;

        // left word in one frame, right word in the next
        wait_mc(500);
        send_word(24'h5A5A5A, 1'b0);
        wait_mc(0);
        chk("split_fa_data", 32'(m_axis_data), 32'(0));
        wait_mc(10);
        send_word(24'hC3C3C3, 1'b1);
        wait_mc(0);
        chk("split_fb_data",  32'(m_axis_data),  32'(0));
        chk("split_fb_ready", 32'(s_axis_ready), 32'(0));
        @(negedge clk);
        chk("split_fc_ready", 32'(s_axis_ready), 32'(1));
        wait_mc(0);
        chk("split_left_data",  32'(m_axis_data), 32'h005A5A5A);
        chk("split_left_last",  32'(m_axis_last), 32'(0));
        @(negedge clk);
        chk("split_right_data", 32'(m_axis_data), 32'h00C3C3C3);
        chk("split_right_last", 32'(m_axis_last), 32'(1));

        // randomized traffic, model-checked every cycle
        for (int i = 0; i < 8 * 512; i++) begin
            s_axis_valid = ($urandom_range(0, 15) == 0);
            s_axis_data  = DW'($urandom);
            s_axis_last  = 1'($urandom_range(0, 1));
            m_axis_ready = (i >= 1500 && i < 2300) ? 1'b0 : ($urandom_range(0, 3) != 0);
            rx_rand      = 1'($urandom_range(0, 1));
            if ((i % 1024) == 0) lb = ~lb;
            resetn       = (i != 3000);
            @(negedge clk);
        end
        s_axis_valid = 1'b0;
        resetn       = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
